clock_time_counter: RTL and testbench

CLOCK_TIME_COUNTER -- requirements
Module: clock_time_counter

---
 rtl/clock_time_counter.sv | 150 +++++++++++++++
 tb/tb_clock_time_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// BCD time-of-day counter with RUN / SET_HR / SET_MIN setting FSM.
// Define HOUR12_EN for 12-hour operation with a PM indicator; 24-hour otherwise.
module clock_time_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       sec,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] hr_t,
  output logic [3:0] hr_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [1:0] mode,
  output logic       day,
  output logic       pm
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

`ifdef HOUR12_EN
  localparam logic [7:0] HR_RST = 8'h12;
`else
  localparam logic [7:0] HR_RST = 8'h00;
`endif

  state_t     r_state;
  logic [7:0] r_hr;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic       r_day;
  logic       r_pm;
  logic       r_sec_p;
  logic       r_mode_p;
  logic       r_inc_p;

  logic       w_tick;
  logic       w_mode;
  logic       w_inc;
  logic       w_hr_carry;
  logic [7:0] w_tk_sec;
  logic [7:0] w_tk_min;
  logic [7:0] w_tk_hr;
  logic       w_tk_pm_tog;
  logic       w_tk_day;
  logic       w_inc_pm_tog;

  // BCD 00..59 increment with wrap
  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_hr(input logic [7:0] v);
`ifdef HOUR12_EN
    if (v == 8'h12) return 8'h01;
`else
    if (v == 8'h23) return 8'h00;
`endif
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_tick = sec & ~r_sec_p;
  assign w_mode = mode_btn & ~r_mode_p;
  assign w_inc  = inc_btn & ~r_inc_p;

  // Time after one running second, with carries
  assign w_hr_carry = (r_sec == 8'h59) & (r_min == 8'h59);
  assign w_tk_sec   = inc60(r_sec);
  assign w_tk_min   = (r_sec == 8'h59) ? inc60(r_min) : r_min;
  assign w_tk_hr    = w_hr_carry ? inc_hr(r_hr) : r_hr;

`ifdef HOUR12_EN
  assign w_tk_pm_tog  = w_hr_carry & (r_hr == 8'h11);
  assign w_tk_day     = w_tk_pm_tog & r_pm;
  assign w_inc_pm_tog = (r_hr == 8'h11);
`else
  assign w_tk_pm_tog  = 1'b0;
  assign w_tk_day     = w_hr_carry & (r_hr == 8'h23);
  assign w_inc_pm_tog = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= RUN;
      r_hr     <= HR_RST;
      r_min    <= 8'h00;
      r_sec    <= 8'h00;
      r_day    <= 1'b0;
      r_pm     <= 1'b0;
      r_sec_p  <= 1'b0;
      r_mode_p <= 1'b0;
      r_inc_p  <= 1'b0;
    end else begin
      r_sec_p  <= sec;
      r_mode_p <= mode_btn;
      r_inc_p  <= inc_btn;
      r_day    <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_tick) begin
            r_sec <= w_tk_sec;
            r_min <= w_tk_min;
            r_hr  <= w_tk_hr;
            r_day <= w_tk_day;
            if (w_tk_pm_tog) r_pm <= ~r_pm;
          end
          // Mode wins the seconds field: tick carries land, seconds restart at 00
          if (w_mode) begin
            r_state <= SET_HR;
            r_sec   <= 8'h00;
          end
        end
        SET_HR: begin
          if (w_mode) begin
            r_state <= SET_MIN;
          end else if (w_inc) begin
            r_hr <= inc_hr(r_hr);
            if (w_inc_pm_tog) r_pm <= ~r_pm;
          end
        end
        SET_MIN: begin
          if (w_mode) begin
            r_state <= RUN;
          end else if (w_inc) begin
            r_min <= inc60(r_min);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign hr_t  = r_hr[7:4];
  assign hr_u  = r_hr[3:0];
  assign min_t = r_min[7:4];
  assign min_u = r_min[3:0];
  assign sec_t = r_sec[7:4];
  assign sec_u = r_sec[3:0];
  assign mode  = r_state;
  assign day   = r_day;
  assign pm    = r_pm;

endmodule

// File: tb/tb_clock_time_counter.sv
// Randomized + directed bench for clock_time_counter against a seconds-of-day model.
module tb_clock_time_counter;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       sec = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
  logic [1:0] mode;
  logic       day, pm;

  clock_time_counter dut (
    .clk(clk), .clr(clr), .sec(sec), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
    .sec_t(sec_t), .sec_u(sec_u), .mode(mode), .day(day), .pm(pm)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int day_cnt = 0;
  bit started = 1'b0;

  // Model state: time as seconds since midnight (24h), mode number, day pulse
  int m_secs = 0;
  int m_mode = 0;
  bit m_day = 1'b0;
  bit m_psec = 1'b0, m_pmode = 1'b0, m_pinc = 1'b0;

  always @(posedge clk) begin
    int s, md, mm;
    bit d, tk, ms, ic;
    s = m_secs; md = m_mode; d = 1'b0;
    if (clr) begin
      s = 0; md = 0;
      m_psec <= 1'b0; m_pmode <= 1'b0; m_pinc <= 1'b0;
    end else begin
      tk = sec & ~m_psec;
      ms = mode_btn & ~m_pmode;
      ic = inc_btn & ~m_pinc;
      case (md)
        0: begin
          if (tk) begin
            if (s == 86399) d = 1'b1;
            s = (s + 1) % 86400;
          end
          if (ms) begin
            md = 1;
            s = s - (s % 60);
          end
        end
        1: if (ms) md = 2; else if (ic) s = (s + 3600) % 86400;
        default: begin
          if (ms) md = 0;
          else if (ic) begin
            mm = (s / 60) % 60;
            s = s - mm * 60 + ((mm + 1) % 60) * 60;
          end
        end
      endcase
      m_psec <= sec; m_pmode <= mode_btn; m_pinc <= inc_btn;
    end
    m_secs <= s; m_mode <= md; m_day <= d;
  end

  function automatic logic [27:0] pack(input int dh, input int m, input int s,
                                       input int md, input bit d, input bit p);
    return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            2'(md), d, p};
  endfunction

  function automatic logic [27:0] model_vec();
    int h, dh;
    bit p;
    h = m_secs / 3600;
`ifdef HOUR12_EN
    dh = (h % 12 == 0) ? 12 : h % 12;
    p = (h >= 12);
`else
    dh = h;
    p = 1'b0;
`endif
    return pack(dh, (m_secs / 60) % 60, m_secs % 60, m_mode, m_day, p);
  endfunction

  logic [27:0] act_vec;
  assign act_vec = {hr_t, hr_u, min_t, min_u, sec_t, sec_u, mode, day, pm};

  always @(negedge clk) begin
    if (started) begin
      n_vec++;
      if (act_vec !== model_vec()) begin
        n_err++;
        $display("FAIL cycle_check t=%0t got=%h want=%h", $time, act_vec, model_vec());
      end
    end
  end

  always @(negedge clk) if (day === 1'b1) day_cnt++;

  task automatic step(input logic s, input logic m, input logic i, input logic c);
    sec = s; mode_btn = m; inc_btn = i; clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic tick();
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
  endtask

  task automatic press_mode();
    step(0, 1, 0, 0); step(0, 0, 0, 0);
  endtask

  task automatic press_inc(input logic s);
    step(s, 0, 1, 0); step(~s, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 0);
  endtask

  task automatic check_lit(input string name, input int dh, input int m, input int s,
                           input int md, input bit p);
    logic [27:0] want;
    want = pack(dh, m, s, md, 1'b0, p);
    n_vec++;
    if ({act_vec[27:2], act_vec[0]} !== {want[27:2], want[0]}) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act_vec, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

`ifdef HOUR12_EN
  localparam int H0 = 12;
  localparam int H23 = 11;
  localparam bit P23 = 1'b1;
`else
  localparam int H0 = 0;
  localparam int H23 = 23;
  localparam bit P23 = 1'b0;
`endif

  initial begin
    int d0;
    step(0, 0, 0, 1);
    started = 1'b1;
    step(0, 0, 0, 1);
    check_lit("reset", H0, 0, 0, 0, 1'b0);

    // 61 seconds from reset
    d0 = day_cnt;
    for (int k = 0; k < 61; k++) tick();
    check_lit("run_61", H0, 1, 1, 0, 1'b0);
    check_int("no_day_61", day_cnt - d0, 0);

    // Preload 23:59:58 and roll over midnight
    do_reset();
    press_mode();
    for (int k = 0; k < 23; k++) press_inc(1'b0);
    press_mode();
    for (int k = 0; k < 59; k++) press_inc(1'b0);
    press_mode();
    for (int k = 0; k < 58; k++) tick();
    check_lit("preload", H23, 59, 58, 0, P23);
    d0 = day_cnt;
    tick();
    check_lit("at_59", H23, 59, 59, 0, P23);
    check_int("no_day_early", day_cnt - d0, 0);
    tick();
    check_lit("midnight", H0, 0, 0, 0, 1'b0);
    check_int("day_once", day_cnt - d0, 1);

    // Setting wraps with ticks flying
    do_reset();
    d0 = day_cnt;
    press_mode();
    for (int k = 0; k < 25; k++) press_inc(1'b1);
    check_lit("set_hr_25", 1, 0, 0, 1, 1'b0);
    press_mode();
    for (int k = 0; k < 60; k++) press_inc(1'b1);
    check_lit("set_min_60", 1, 0, 0, 2, 1'b0);
    check_int("no_day_set", day_cnt - d0, 0);
    press_mode();
    tick();
    check_lit("resume", 1, 0, 1, 0, 1'b0);

    // Held sec gives one tick; mode+inc together applies mode only
    do_reset();
    for (int k = 0; k < 10; k++) step(1, 0, 0, 0);
    check_lit("held_sec", H0, 0, 1, 0, 1'b0);
    step(1, 1, 1, 0); step(0, 0, 0, 0);
    check_lit("mode_inc", H0, 0, 0, 1, 1'b0);

    // Tick and mode in the same clk at :59
    do_reset();
    for (int k = 0; k < 59; k++) tick();
    step(1, 1, 0, 0); step(0, 0, 0, 0);
    check_lit("tick_mode", H0, 1, 0, 1, 1'b0);

    // clr mid-setting, and sec already high at clr release
    press_mode();
    press_inc(1'b0);
    step(1, 0, 1, 1);
    check_lit("clr_mid_set", H0, 0, 0, 0, 1'b0);
    step(1, 0, 0, 0);
    check_lit("sec_at_release", H0, 0, 1, 0, 1'b0);

    // Random traffic against the model
    for (int k = 0; k < 4000; k++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 499) == 0));

    step(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
